// File: rtl/seq_div_128x64.sv
// Restoring divider: 2W-bit dividend / W-bit divisor -> 2W-bit quotient, W-bit remainder.
// Latency: 2W+1 cycles from accept to done (one quotient bit per clock); divide-by-zero answers after the accepting edge.
// Backpressure: none; start is only sampled in IDLE and ignored while a division runs or completes.
module seq_div_128x64 #(
  parameter int W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2*W-1:0]   dividend,
  input  logic [W-1:0]     divisor,
  output logic             busy,
  output logic             done,
  output logic [2*W-1:0]   quotient,
  output logic [W-1:0]     remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(2*W) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;

  // Dividend shift register; quotient bits enter at the LSB as dividend bits leave the MSB.
  logic [2*W-1:0]  dvd_q, dvd_d;
  logic [W-1:0]    dvs_q, dvs_d;
  // Partial remainder is always < divisor after a step, so W bits suffice between steps.
  logic [W-1:0]    p_q, p_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [2*W-1:0]  quo_q, quo_d;
  logic [W-1:0]    rem_q, rem_d;
  logic            dz_q, dz_d;

  // One restoring step: the shifted partial remainder needs W+1 bits before subtracting.
  logic [W:0]      p_shift;
  logic [W-1:0]    p_sub;
  logic            q_bit;
  logic            last_step;

  assign p_shift   = {p_q, dvd_q[2*W-1]};
  // When the top bit is set the value exceeds any W-bit divisor, and the W-bit
  // difference is exact because the true result is below the divisor.
  assign q_bit     = p_shift[W] | (p_shift[W-1:0] >= dvs_q);
  assign p_sub     = p_shift[W-1:0] - dvs_q;
  assign last_step = (cnt_q == CW'(1));

  // State and datapath registers, cleared asynchronously so an in-flight division is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
    end
  end

  // Next-state: zero divisor short-circuits straight to DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = (divisor == '0) ? S_DONE : S_CALC;
      S_CALC: if (last_step) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next-values: operand capture, one iteration per CALC cycle, result capture.
  always_comb begin
    dvd_d = dvd_q;
    dvs_d = dvs_q;
    p_d   = p_q;
    cnt_d = cnt_q;
    quo_d = quo_q;
    rem_d = rem_q;
    dz_d  = dz_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (divisor != '0) begin
            dvd_d = dividend;
            dvs_d = divisor;
            p_d   = '0;
            cnt_d = CW'(2*W);
          end else begin
            quo_d = '1;
            rem_d = dividend[W-1:0];
            dz_d  = 1'b1;
          end
        end
      end
      S_CALC: begin
        p_d   = q_bit ? p_sub : p_shift[W-1:0];
        dvd_d = {dvd_q[2*W-2:0], q_bit};
        cnt_d = cnt_q - CW'(1);
        if (last_step) begin
          quo_d = {dvd_q[2*W-2:0], q_bit};
          rem_d = q_bit ? p_sub : p_shift[W-1:0];
          dz_d  = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Status outputs decoded from the registered state only.
  always_comb begin
    busy = (state_q == S_CALC);
    done = (state_q == S_DONE);
  end

  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dz_q;

endmodule

// File: tb/tb_seq_div_128x64.sv
// Bench for seq_div_128x64 at W=64: directed table, random vectors vs arithmetic model,
// start-held protocol run, and asynchronous reset in the middle of a division.
module tb_seq_div_128x64;

  logic          clk;
  logic          rst;
  logic          start;
  logic [127:0]  dividend;
  logic [63:0]   divisor;
  logic          busy;
  logic          done;
  logic [127:0]  quotient;
  logic [63:0]   remainder;
  logic          div_by_zero;

  int n_assert = 0;
  int n_fail   = 0;

  seq_div_128x64 #(.W(64)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference: plain integer division, with the fixed answer for a zero divisor.
  function automatic void model(input logic [127:0] a, input logic [63:0] b,
                                output logic [127:0] q, output logic [63:0] r,
                                output logic dz);
    logic [127:0] bw;
    logic [127:0] rw;
    if (b == 64'd0) begin
      q  = '1;
      r  = a[63:0];
      dz = 1'b1;
    end else begin
      bw = {64'd0, b};
      q  = a / bw;
      rw = a % bw;
      r  = rw[63:0];
      dz = 1'b0;
    end
  endfunction

  // busy/done exclusivity and single-cycle done, checked every cycle outside reset.
  logic done_prev = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      chk("busy_done_exclusive", {127'd0, busy & done}, 128'd0);
      chk("done_one_cycle", {127'd0, done & done_prev}, 128'd0);
      done_prev = done;
    end else begin
      done_prev = 1'b0;
    end
  end

  task automatic wait_idle();
    int guard;
    @(negedge clk);
    guard = 0;
    while ((busy || done) && guard < 400) begin
      @(negedge clk);
      guard++;
    end
  endtask

  // lat = edges after the accepting edge until done is seen.
  task automatic run_div(input logic [127:0] a, input logic [63:0] b,
                         output logic [127:0] q, output logic [63:0] r,
                         output logic dz, output int lat);
    wait_idle();
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = ~a;
    divisor  = b ^ 64'h5A5A_0F0F_3C3C_9999;
    lat = 0;
    while (!done && lat < 400) begin
      @(posedge clk);
      #1;
      lat++;
    end
    q  = quotient;
    r  = remainder;
    dz = div_by_zero;
  endtask

  typedef struct {
    string        name;
    logic [127:0] a;
    logic [63:0]  b;
    logic [127:0] q;
    logic [63:0]  r;
    logic         dz;
    int           lat;
  } vec_t;

  vec_t tbl [9];

  logic [127:0] gq, eq;
  logic [63:0]  gr, er;
  logic         gdz, edz;
  int           glat;

  logic [127:0] op_a [390];
  logic [63:0]  op_b [390];
  int           n_done;
  logic [127:0] held_q;
  logic [63:0]  held_r;
  logic         seen_done;

  initial begin
    tbl[0] = '{"rt_42_6",      128'd42,      64'd6,    128'd7,    64'd0,    1'b0, 128};
    tbl[1] = '{"rt_65025_255", 128'd65025,   64'd255,  128'd255,  64'd0,    1'b0, 128};
    tbl[2] = '{"rt_1e6_1000",  128'd1000000, 64'd1000, 128'd1000, 64'd0,    1'b0, 128};
    tbl[3] = '{"rem_1000001",  128'd1000001, 64'd1000, 128'd1000, 64'd1,    1'b0, 128};
    tbl[4] = '{"rem_254_255",  128'd254,     64'd255,  128'd0,    64'd254,  1'b0, 128};
    tbl[5] = '{"max_by_max",   {128{1'b1}},  {64{1'b1}},
               128'h0000_0000_0000_0001_0000_0000_0000_0001, 64'd0, 1'b0, 128};
    tbl[6] = '{"max_by_one",   {128{1'b1}},  64'd1,    {128{1'b1}}, 64'd0,  1'b0, 128};
    tbl[7] = '{"div_zero",     128'd1234,    64'd0,    {128{1'b1}}, 64'd1234, 1'b1, 0};
    tbl[8] = '{"after_zero",   128'd42,      64'd6,    128'd7,    64'd0,    1'b0, 128};

    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #2;
    chk("reset_busy",   {127'd0, busy},        128'd0);
    chk("reset_done",   {127'd0, done},        128'd0);
    chk("reset_quot",   quotient,              128'd0);
    chk("reset_rem",    {64'd0, remainder},    128'd0);
    chk("reset_dz",     {127'd0, div_by_zero}, 128'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Directed table
    for (int i = 0; i < 9; i++) begin
      run_div(tbl[i].a, tbl[i].b, gq, gr, gdz, glat);
      chk({tbl[i].name, "_quot"}, gq, tbl[i].q);
      chk({tbl[i].name, "_rem"},  {64'd0, gr},  {64'd0, tbl[i].r});
      chk({tbl[i].name, "_dz"},   {127'd0, gdz}, {127'd0, tbl[i].dz});
      chk({tbl[i].name, "_lat"},  128'(glat),   128'(tbl[i].lat));
    end

    // Random vectors against the model, divisor widths spread by a random shift
    for (int i = 0; i < 20; i++) begin
      logic [127:0] a;
      logic [63:0]  b;
      a = {$urandom, $urandom, $urandom, $urandom};
      b = {$urandom, $urandom} >> $urandom_range(0, 63);
      if (i % 5 == 4) a = a >> $urandom_range(0, 127);
      model(a, b, eq, er, edz);
      run_div(a, b, gq, gr, gdz, glat);
      chk("rand_quot", gq, eq);
      chk("rand_rem",  {64'd0, gr}, {64'd0, er});
      chk("rand_dz",   {127'd0, gdz}, {127'd0, edz});
      chk("rand_lat",  128'(glat), (b == 64'd0) ? 128'd0 : 128'd128);
    end

    // start held high, operands changing every cycle: accepts at edges 0, 130, 260
    wait_idle();
    n_done = 0;
    held_q = '0;
    held_r = '0;
    for (int i = 0; i < 390; i++) begin
      if (i == 0) begin
        op_a[i] = 128'd42;
        op_b[i] = 64'd6;
      end else begin
        op_a[i] = {$urandom, $urandom, $urandom, $urandom};
        op_b[i] = {$urandom, $urandom | 32'd1} >> $urandom_range(0, 40);
        if (op_b[i] == 64'd0) op_b[i] = 64'd3;
      end
      dividend = op_a[i];
      divisor  = op_b[i];
      start    = 1'b1;
      @(posedge clk);
      #1;
      if (done) begin
        chk("proto_done_edge", 128'(i), 128'(128 + 130 * n_done));
        if (n_done < 3) begin
          model(op_a[130 * n_done], op_b[130 * n_done], eq, er, edz);
          chk("proto_quot", quotient, eq);
          chk("proto_rem",  {64'd0, remainder}, {64'd0, er});
          held_q = eq;
          held_r = er;
        end
        n_done++;
      end else if (n_done > 0) begin
        chk("hold_quot", quotient, held_q);
        chk("hold_rem",  {64'd0, remainder}, {64'd0, held_r});
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("proto_done_count", 128'(n_done), 128'd3);

    // Asynchronous reset during iteration 60 of 42/6
    wait_idle();
    dividend = 128'd42;
    divisor  = 64'd6;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (59) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_busy",  {127'd0, busy},        128'd0);
    chk("arst_done",  {127'd0, done},        128'd0);
    chk("arst_quot",  quotient,              128'd0);
    chk("arst_rem",   {64'd0, remainder},    128'd0);
    chk("arst_dz",    {127'd0, div_by_zero}, 128'd0);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) seen_done = 1'b1;
    end
    chk("arst_no_done", {127'd0, seen_done}, 128'd0);
    run_div(128'd65025, 64'd255, gq, gr, gdz, glat);
    chk("post_rst_quot", gq, 128'd255);
    chk("post_rst_rem",  {64'd0, gr}, 128'd0);
    chk("post_rst_dz",   {127'd0, gdz}, 128'd0);
    chk("post_rst_lat",  128'(glat), 128'd128);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
